// File: rtl/multi_word_add_seq.sv
// multi_word_add_seq: adds two W-bit operands (W = N*WORDS) one N-bit word per
// cycle, least significant word first, using an external combinational N-bit
// adder stage driven through add_a/add_b/add_cin and read back on add_sum/add_cout.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request to add op_a + op_b + cin (accepted only in IDLE)
//   op_a      wide operand A (W bits)
//   op_b      wide operand B (W bits)
//   cin       initial carry-in
//   busy      high while in RUN or DONE
//   done      one-cycle pulse, result/cout valid
//   result    wide sum (W bits), holds its value while idle
//   cout      final carry-out
//   add_a     word to adder A input (N bits)
//   add_b     word to adder B input (N bits)
//   add_cin   carry to adder Cin
//   add_sum   adder Sum, combinational from add_a/add_b/add_cin
//   add_cout  adder Cout, combinational, same cycle

module multi_word_add_seq #(
   parameter int unsigned N     = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N*WORDS-1:0]   op_a,
   input  logic [N*WORDS-1:0]   op_b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [N*WORDS-1:0]   result,
   output logic                 cout,
   output logic [N-1:0]         add_a,
   output logic [N-1:0]         add_b,
   output logic                 add_cin,
   input  logic [N-1:0]         add_sum,
   input  logic                 add_cout
);

   localparam int unsigned W  = N * WORDS;
   localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e          state_q;
   logic [W-1:0]    op_a_q;
   logic [W-1:0]    op_b_q;
   logic [W-1:0]    result_q;
   logic [IW-1:0]   idx_q;
   logic            carry_q;
   logic            cout_q;
   logic            busy_q;
   logic            done_q;
   logic [N-1:0]    add_a_q;
   logic [N-1:0]    add_b_q;

   // Word i of a wide vector; i == WORDS yields 0 (shift past the top).
   function automatic logic [N-1:0] word_of(input logic [W-1:0] v, input int unsigned i);
      word_of = N'(v >> (i * N));
   endfunction

   // Adder operands are registered one cycle ahead: they are loaded with the
   // word the next RUN cycle needs, so the adder sees stable register outputs.
   // The carry register doubles as add_cin and is cleared outside RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         add_a_q  <= '0;
         add_b_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_a_q  <= op_a;
                  op_b_q  <= op_b;
                  carry_q <= cin;
                  idx_q   <= '0;
                  add_a_q <= word_of(op_a, 32'd0);
                  add_b_q <= word_of(op_b, 32'd0);
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end

            S_RUN: begin
               result_q[32'(idx_q) * N +: N] <= add_sum;
               if (idx_q == LAST_IDX) begin
                  // Last word: final carry goes to cout, adder inputs go quiet.
                  cout_q  <= add_cout;
                  carry_q <= 1'b0;
                  idx_q   <= '0;
                  add_a_q <= '0;
                  add_b_q <= '0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  carry_q <= add_cout;
                  idx_q   <= idx_q + IW'(1);
                  add_a_q <= word_of(op_a_q, 32'(idx_q) + 32'd1);
                  add_b_q <= word_of(op_b_q, 32'(idx_q) + 32'd1);
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign cout    = cout_q;
   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign add_cin = carry_q;

endmodule

// File: tb/tb_multi_word_add_seq.sv
// Bench for multi_word_add_seq (N=8, WORDS=4) with an exact 8-bit adder model
// attached to the add_* ports and a queue of expected results.
module tb_multi_word_add_seq;

   localparam int unsigned N     = 8;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = N * WORDS;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           cin;
   logic           busy;
   logic           done;
   logic [W-1:0]   result;
   logic           cout;
   logic [N-1:0]   add_a;
   logic [N-1:0]   add_b;
   logic           add_cin;
   logic [N-1:0]   add_sum;
   logic           add_cout;
   logic [N:0]     sum9;

   always #5 clk = ~clk;

   multi_word_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Exact N-bit adder stage.
   assign sum9     = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
   assign add_sum  = sum9[N-1:0];
   assign add_cout = sum9[N];

   typedef struct {
      logic [W-1:0] r;
      logic         c;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] r;
      logic         co;
      int           ones;   // expected RUN cycles with add_cin=1, -1 = not checked
      string        nm;
   } vec_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic push_exp(input logic [W-1:0] r, input logic c);
      exp_t e;
      e.r = r;
      e.c = c;
      sb_q.push_back(e);
   endtask

   // Present a request at a negedge, let it be accepted, then scramble inputs.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      cin   = 1'($urandom_range(0, 1));
   endtask

   // Follow one operation from just after its accepting edge to the cycle after done.
   task automatic watch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input string nm, output int cin_ones);
      int         lat;
      bit         bad;
      logic       cy;
      logic [N:0] t;
      exp_t       e;
      lat      = 0;
      bad      = 1'b0;
      cy       = c;
      cin_ones = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (k > int'(WORDS)) begin
            bad = 1'b1;
            continue;
         end
         if (add_a !== a[(k-1)*N +: N]) bad = 1'b1;
         if (add_b !== b[(k-1)*N +: N]) bad = 1'b1;
         if (add_cin !== cy) bad = 1'b1;
         if (busy !== 1'b1) bad = 1'b1;
         if (add_cin === 1'b1) cin_ones++;
         t  = {1'b0, a[(k-1)*N +: N]} + {1'b0, b[(k-1)*N +: N]} + {{N{1'b0}}, cy};
         cy = t[N];
      end
      chk({nm, " latency"}, 64'(lat), 64'(WORDS + 1));
      chk({nm, " run words"}, 64'(bad), 64'd0);
      if (sb_q.size() == 0) begin
         chk({nm, " scoreboard empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         chk({nm, " result"}, 64'(result), 64'(e.r));
         chk({nm, " cout"}, 64'(cout), 64'(e.c));
      end
      chk({nm, " done-state busy/add"}, 64'({busy, add_a, add_b, add_cin}), 64'({1'b1, 17'h0}));
      @(negedge clk);
      chk({nm, " after done done/busy"}, 64'({done, busy}), 64'd0);
   endtask

   initial begin
      vec_t         vec [6];
      int           ones;
      logic [W-1:0] ra, rb, rr;
      logic         rc, rco;
      logic [W-1:0] last_r;
      logic         last_c;
      bit           saw_done;

      vec[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, -1, "ff_plus_1"};
      vec[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1,  4, "all_ones_cin"};
      vec[2] = '{32'd20,        32'd40,        1'b1, 32'h0000_003D, 1'b0, -1, "20_40_cin"};
      vec[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1,  4, "max_max_cin"};
      vec[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0,  2, "alt_carry"};
      vec[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0,  3, "ripple_3"};

      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", 64'({busy, done, cout, add_a, add_b, add_cin}), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 6; i++) begin
         push_exp(vec[i].r, vec[i].co);
         accept(vec[i].a, vec[i].b, vec[i].ci);
         watch(vec[i].a, vec[i].b, vec[i].ci, vec[i].nm, ones);
         if (vec[i].ones >= 0) chk({vec[i].nm, " add_cin ones"}, 64'(ones), 64'(vec[i].ones));
         last_r = vec[i].r;
         last_c = vec[i].co;
      end

      // Result and cout hold while idle.
      repeat (3) @(negedge clk);
      chk("idle hold", 64'({cout, result}), 64'({last_c, last_r}));

      // Random operands against a wide-sum reference.
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         {rco, rr} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         push_exp(rr, rco);
         accept(ra, rb, rc);
         watch(ra, rb, rc, $sformatf("rand%0d", i), ones);
      end

      // Reset wins over start in the same cycle.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      op_a  = 32'h1111_1111;
      op_b  = 32'h2222_2222;
      @(posedge clk);
      #1;
      chk("rst over start busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst over start outputs", 64'({busy, done, cout, result}), 64'd0);

      // start held through RUN/DONE with different operands.
      push_exp(32'h0000_0000, 1'b1);
      @(negedge clk);
      op_a  = 32'h8000_0000;
      op_b  = 32'h8000_0000;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      op_a = 32'h0000_1234;
      op_b = 32'h0000_0001;
      cin  = 1'b1;
      push_exp(32'h0000_1236, 1'b0);
      watch(32'h8000_0000, 32'h8000_0000, 1'b0, "held_first", ones);
      @(posedge clk);
      #1;
      chk("held_second accepted", 64'(busy), 64'd1);
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      watch(32'h0000_1234, 32'h0000_0001, 1'b1, "held_second", ones);

      // Reset on the second RUN cycle abandons the operation.
      accept(32'hDEAD_BEEF, 32'h0102_0304, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid-run rst outputs", 64'({busy, done, cout, add_a, add_b, add_cin}), 64'd0);
      chk("mid-run rst result", 64'(result), 64'd0);
      rst      = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      end
      chk("no done after rst", 64'(saw_done), 64'd0);
      push_exp(32'h2345_6789, 1'b0);
      accept(32'h1234_5678, 32'h1111_1111, 1'b0);
      watch(32'h1234_5678, 32'h1111_1111, 1'b0, "post_rst", ones);

      chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
